// File: rtl/i2c_bit_counter.sv
// i2c_bit_counter: I2C frame bit counter with START/STOP detection, data/ACK phase flags and byte counting.
// Bus events are registered once after synchronisation, so every output lags a pin change by SYNC_STAGES+1 edges.
module i2c_bit_counter #(
   parameter int BITS_PER_FRAME = 8,
   parameter int ACK_EN = 1,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W = 4,
   parameter int BYTE_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic [CNT_W-1:0]  bit_cnt,
   output logic              data_phase,
   output logic              ack_phase,
   output logic              busy,
   output logic              byte_done,
   output logic              start_det,
   output logic              stop_det,
   output logic [BYTE_W-1:0] byte_cnt
);
   typedef enum logic [1:0] {IDLE, DATA, ACK} state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BITS_PER_FRAME - 1);
   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic scl_s, sda_s, scl_p_q, sda_p_q, rise_q, start_q, stop_q;
   state_t state_q;
   logic [CNT_W-1:0] bit_cnt_q;
   logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
   logic byte_done_q, start_det_q, stop_det_q;
   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];
   assign byte_cnt_d = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 1'b1;
   // Flops preset to the idle-high bus level so reset release cannot fake an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_p_q    <= 1'b1;
         sda_p_q    <= 1'b1;
         rise_q     <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
         scl_p_q    <= scl_s;
         sda_p_q    <= sda_s;
         rise_q     <= scl_s & ~scl_p_q;
         start_q    <= scl_s & scl_p_q & sda_p_q & ~sda_s;
         stop_q     <= scl_s & scl_p_q & ~sda_p_q & sda_s;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         byte_done_q <= 1'b0;
         start_det_q <= 1'b0;
         stop_det_q  <= 1'b0;
      end else begin
         byte_done_q <= 1'b0;
         start_det_q <= 1'b0;
         stop_det_q  <= 1'b0;
         if (!en) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
         end else if (stop_q) begin
            stop_det_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
         end else if (start_q) begin
            start_det_q <= 1'b1;
            state_q     <= DATA;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
         end else if (rise_q && state_q == DATA) begin
            if (bit_cnt_q < LAST) begin
               bit_cnt_q <= bit_cnt_q + 1'b1;
            end else if (ACK_EN != 0) begin
               state_q   <= ACK;
               bit_cnt_q <= '0;
            end else begin
               byte_done_q <= 1'b1;
               byte_cnt_q  <= byte_cnt_d;
               bit_cnt_q   <= '0;
            end
         end else if (rise_q && state_q == ACK) begin
            byte_done_q <= 1'b1;
            byte_cnt_q  <= byte_cnt_d;
            state_q     <= DATA;
            bit_cnt_q   <= '0;
         end
      end
   end
   assign bit_cnt    = bit_cnt_q;
   assign byte_cnt   = byte_cnt_q;
   assign byte_done  = byte_done_q;
   assign start_det  = start_det_q;
   assign stop_det   = stop_det_q;
   assign data_phase = state_q == DATA;
   assign ack_phase  = state_q == ACK;
   assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_i2c_bit_counter.sv
// tb_i2c_bit_counter: directed bus sequences on three parameter variants sharing one bus.
module tb_i2c_bit_counter;
   logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, scl = 1'b1, sda = 1'b1;
   logic [2:0] bd, sd, pd, busy, dp, ap;
   logic [3:0] bc0, bc1, bc2;
   logic [7:0] yc0, yc1;
   logic [1:0] yc2;
   int nd[3] = '{0, 0, 0};
   int ns[3] = '{0, 0, 0};
   int np[3] = '{0, 0, 0};
   int n_chk = 0, n_fail = 0;
   logic ack1_seen = 1'b0;
   logic [3:0] max1 = '0;
   always #5 clk = ~clk;

   i2c_bit_counter dut0 (.clk(clk), .rst_n(rst_n), .en(en), .scl_in(scl), .sda_in(sda),
      .bit_cnt(bc0), .data_phase(dp[0]), .ack_phase(ap[0]), .busy(busy[0]), .byte_done(bd[0]),
      .start_det(sd[0]), .stop_det(pd[0]), .byte_cnt(yc0));
   i2c_bit_counter #(.BITS_PER_FRAME(11), .ACK_EN(0)) dut1 (.clk(clk), .rst_n(rst_n), .en(en),
      .scl_in(scl), .sda_in(sda), .bit_cnt(bc1), .data_phase(dp[1]), .ack_phase(ap[1]),
      .busy(busy[1]), .byte_done(bd[1]), .start_det(sd[1]), .stop_det(pd[1]), .byte_cnt(yc1));
   i2c_bit_counter #(.BYTE_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .en(en), .scl_in(scl), .sda_in(sda),
      .bit_cnt(bc2), .data_phase(dp[2]), .ack_phase(ap[2]), .busy(busy[2]), .byte_done(bd[2]),
      .start_det(sd[2]), .stop_det(pd[2]), .byte_cnt(yc2));

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         nd[i] <= nd[i] + int'(bd[i]);
         ns[i] <= ns[i] + int'(sd[i]);
         np[i] <= np[i] + int'(pd[i]);
      end
      if (ap[1]) ack1_seen <= 1'b1;
      if (bc1 > max1) max1 <= bc1;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bit_(input logic b);
      scl = 1'b0; tick(8);
      sda = b;    tick(8);
      scl = 1'b1; tick(8);
   endtask

   task automatic start_();
      scl = 1'b0; tick(8);
      sda = 1'b1; tick(8);
      scl = 1'b1; tick(8);
      sda = 1'b0; tick(8);
   endtask

   task automatic stop_();
      scl = 1'b0; tick(8);
      sda = 1'b0; tick(8);
      scl = 1'b1; tick(8);
      sda = 1'b1; tick(8);
   endtask

   task automatic byte_(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) bit_(d[i]);
      bit_(1'b0);
   endtask

   initial begin
      int s_d, s_s, s_p, s_d1;
      logic [7:0] pat;
      tick(5);
      chk("reset_flags", {busy, dp, ap, bd, sd, pd}, 0);
      chk("reset_cnts", {bc0, bc1, bc2, yc0, yc1, yc2}, 0);
      rst_n = 1'b1;
      tick(10);
      chk("no_false_edge", ns[0] + nd[0] + np[0], 0);

      // single byte 0xA5 with ACK
      s_d = nd[0]; s_s = ns[0]; s_p = np[0];
      pat = 8'hA5;
      start_();
      chk("t1_start_det", ns[0] - s_s, 1);
      chk("t1_busy_data", {busy[0], dp[0], bc0}, {1'b1, 1'b1, 4'd0});
      for (int i = 0; i < 8; i++) begin
         bit_(pat[7-i]);
         if (i < 7) chk("t1_bit_cnt", bc0, i + 1);
      end
      chk("t1_ack_phase", {ap[0], dp[0], bc0}, {1'b1, 1'b0, 4'd0});
      chk("t1_no_done_yet", nd[0] - s_d, 0);
      bit_(1'b0);
      chk("t1_byte_done", nd[0] - s_d, 1);
      chk("t1_byte_cnt", yc0, 1);
      stop_();
      chk("t1_stop_det", np[0] - s_p, 1);
      chk("t1_after_stop", {busy[0], bc0, yc0}, {1'b0, 4'd0, 8'd1});

      // three back-to-back bytes
      s_d = nd[0];
      start_();
      byte_(8'h3C);
      chk("t2_done1", nd[0] - s_d, 1);
      for (int i = 0; i < 8; i++) bit_(1'b1);
      chk("t2_gap", nd[0] - s_d, 1);
      bit_(1'b0);
      chk("t2_done2", nd[0] - s_d, 2);
      byte_(8'h00);
      chk("t2_done3", nd[0] - s_d, 3);
      stop_();
      chk("t2_cnt_held", {yc0, 6'd0, yc2}, {8'd3, 6'd0, 2'd3});

      // repeated START after 5 bits of byte 2
      start_();
      byte_(8'h81);
      chk("t3_cnt1", yc0, 1);
      s_d = nd[0]; s_s = ns[0];
      for (int i = 0; i < 5; i++) bit_(1'b1);
      chk("t3_partial", bc0, 5);
      start_();
      chk("t3_rstart", {ns[0] - s_s, 24'd0, bc0, yc0[3:0]}, {32'd1, 24'd0, 4'd0, 4'd0});
      chk("t3_no_done", nd[0] - s_d, 0);
      byte_(8'h55);
      chk("t3_cnt_new", yc0, 1);
      stop_();

      // 11-bit frames without ACK on dut1
      s_d1 = nd[1];
      start_();
      for (int i = 0; i < 10; i++) bit_(1'b0);
      chk("t4_bit10", bc1, 10);
      chk("t4_no_done", nd[1] - s_d1, 0);
      bit_(1'b1);
      chk("t4_done11", {nd[1] - s_d1, bc1}, {32'd1, 4'd0});
      for (int i = 0; i < 11; i++) bit_(1'b1);
      chk("t4_done22", nd[1] - s_d1, 2);
      chk("t4_cnt", yc1, 2);
      chk("t4_ack_never", ack1_seen, 0);
      chk("t4_max_bit", max1, 10);
      stop_();

      // SCL without START, SDA glitch with SCL low, en low mid-frame
      s_d = nd[0]; s_s = ns[0];
      for (int i = 0; i < 5; i++) bit_(1'b0);
      chk("t5_idle_scl", {busy[0], bc0}, 0);
      scl = 1'b0; tick(8);
      sda = 1'b0; tick(2);
      sda = 1'b1; tick(8);
      scl = 1'b1; tick(8);
      chk("t5_glitch", {ns[0] - s_s, nd[0] - s_d}, 0);
      start_();
      for (int i = 0; i < 3; i++) bit_(1'b1);
      chk("t5_pre_en", bc0, 3);
      s_d = nd[0];
      en = 1'b0;
      tick(1);
      chk("t5_en_low", {busy[0], dp[0], bc0}, 0);
      for (int i = 0; i < 10; i++) bit_(1'b1);
      chk("t5_en_hold", {nd[0] - s_d, 28'd0, bc0}, 0);
      en = 1'b1;
      tick(2);
      chk("t5_en_back", busy[0], 0);
      stop_();

      // BYTE_W=2 saturation, then async reset mid-frame
      start_();
      for (int f = 1; f <= 5; f++) begin
         byte_(8'hF0);
         chk("t6_sat", yc2, (f < 3) ? f : 3);
      end
      for (int i = 0; i < 4; i++) bit_(1'b0);
      chk("t6_mid", {busy[2], bc2}, {1'b1, 4'd4});
      rst_n = 1'b0;
      #1;
      chk("t6_rst_flags", {busy, dp, ap, bd, sd, pd}, 0);
      chk("t6_rst_cnts", {bc0, bc1, bc2, yc0, yc1, yc2}, 0);
      sda = 1'b1;
      tick(3);
      s_d = nd[0] + nd[2]; s_s = ns[0] + ns[2]; s_p = np[0] + np[2];
      rst_n = 1'b1;
      tick(20);
      chk("t6_release", {(nd[0] + nd[2]) - s_d, (ns[0] + ns[2]) - s_s, (np[0] + np[2]) - s_p}, 0);
      chk("t6_idle", {busy, bc2, yc2}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/i2c_bit_counter.md
Name: i2c_bit_counter

Overview:
- Parametrised I2C frame bit counter, run from the fast system clock `clk`.
- Synchronises the raw SCL/SDA bus lines and detects START, repeated START and STOP.
- Counts SCL rising edges within each frame and flags the data and ACK phases.
- Emits a one-cycle pulse per completed byte and counts bytes per transaction for the I2C slave/master controllers.
- Generalises the fixed 11-count counter to any frame length, an optional ACK slot and bus-condition awareness.

Parameters:
- BITS_PER_FRAME, 8: data bits per frame, 1..15.
- ACK_EN, 1: 1 = a ninth ACK clock follows the data bits; 0 = data bits only.
- SYNC_STAGES, 2: synchroniser flops on scl_in/sda_in, minimum 2.
- CNT_W, 4: bit_cnt width; must hold BITS_PER_FRAME-1.
- BYTE_W, 8: byte_cnt width.

Ports:
- clk  in  1  system clock, rising-edge only.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  block enable; low forces IDLE.
- scl_in  in  1  raw SCL line, asynchronous.
- sda_in  in  1  raw SDA line, asynchronous.
- bit_cnt  out  CNT_W  index of the bit currently being clocked in a data phase.
- data_phase  out  1  high while in DATA.
- ack_phase  out  1  high while in ACK.
- busy  out  1  high between START and STOP.
- byte_done  out  1  one-cycle pulse per completed frame.
- start_det  out  1  one-cycle pulse on START or repeated START.
- stop_det  out  1  one-cycle pulse on STOP.
- byte_cnt  out  BYTE_W  frames completed since the last START; saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0; state IDLE.
  - synchroniser and edge-history flops preset to 1, the idle bus level, so release produces no false edges.
- Synchronisers:
  - scl_s/sda_s are the last synchroniser stages; scl_p/sda_p are their one-cycle-delayed copies.
  - scl_rise = scl_s & ~scl_p.
  - start_c = scl_s & scl_p & sda_p & ~sda_s.
  - stop_c = scl_s & scl_p & ~sda_p & sda_s.
  - Requiring SCL high on both samples means a START/STOP can never coincide with scl_rise.
- Output timing: all outputs are registered. A pin change first sampled at edge k appears on outputs after edge k+SYNC_STAGES+1.
- States: IDLE, DATA, ACK.
- Priority each cycle, highest first: ~en, stop_c, start_c, scl_rise.
- ~en: go to IDLE; bit_cnt=0; busy=0; pulses suppressed; byte_cnt held.
- stop_c (any state):
  - stop_det=1; go to IDLE; busy=0; bit_cnt=0.
  - byte_cnt held.
  - A partial frame is discarded: no byte_done.
- start_c (any state, including repeated START mid-frame):
  - start_det=1; go to DATA; busy=1; bit_cnt=0; byte_cnt=0.
  - A partial frame is discarded.
- scl_rise in DATA:
  - if bit_cnt < BITS_PER_FRAME-1: bit_cnt+1.
  - else (last data bit), ACK_EN=1: go to ACK; bit_cnt=0.
  - else (last data bit), ACK_EN=0: byte_done=1; byte_cnt++; bit_cnt=0; stay in DATA.
- scl_rise in ACK: byte_done=1; byte_cnt++; go to DATA; bit_cnt=0.
- scl_rise in IDLE: ignored.
- byte_cnt saturates at all-ones; it never wraps.
- data_phase and ack_phase are decoded from registered state. busy = state != IDLE.
- byte_done, start_det and stop_det are exactly one clk wide. They never overlap each other.
- rst_n asserted mid-frame: immediate return to reset values, no pulses.

Test Plan:
- Reset, then START, 8 SCL pulses with 0xA5 on SDA, 1 ACK pulse, STOP (defaults) -> start_det ×1; bit_cnt steps 0..7; ack_phase high after 8th rise; byte_done ×1 after 9th rise; byte_cnt=1; stop_det ×1; busy 1→0.
- Three back-to-back bytes (27 SCL pulses) then STOP -> byte_done ×3 spaced 9 SCL rises apart; byte_cnt=3 held after STOP.
- Repeated START after 5 data bits of byte 2 -> start_det pulse; bit_cnt=0; byte_cnt=0; no byte_done for the partial byte; the next full frame gives byte_cnt=1.
- ACK_EN=0, BITS_PER_FRAME=11, START then 22 SCL pulses -> byte_done after rises 11 and 22; ack_phase never high; bit_cnt max 10.
- SCL toggling with no START, SDA glitch while SCL low, en low mid-frame -> no byte_done; bit_cnt stays 0; en low forces IDLE within one cycle and busy=0.
- BYTE_W=2, 5 frames -> byte_cnt 1,2,3,3,3 (saturates); rst_n pulsed mid-frame -> all outputs 0 asynchronously; no pulse on release.
